multi_dead_timer: RTL and testbench

MULTI_DEAD_TIMER -- requirements
Module: multi_dead_timer

---
 rtl/multi_dead_timer.sv | 132 +++++++++++++
 tb/tb_multi_dead_timer.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/multi_dead_timer.sv
// Multi-channel complementary PWM dead-time generator.
// Each channel runs its own handover FSM and dead-time down-counter.
module multi_dead_timer #(
  parameter int NUM_CH = 3,
  parameter int CNT_W  = 16
) (
  input  logic              MClk,
  input  logic              Rst,
  input  logic              Enable,
  input  logic [NUM_CH-1:0] PwmIn,
  input  logic [CNT_W-1:0]  RiseDead,
  input  logic [CNT_W-1:0]  FallDead,
  output logic [NUM_CH-1:0] HiOut,
  output logic [NUM_CH-1:0] LoOut,
  output logic [NUM_CH-1:0] DtActive
);

  typedef enum logic [2:0] {
    S_OFF      = 3'd0,
    S_LO_ON    = 3'd1,
    S_DT_TO_HI = 3'd2,
    S_HI_ON    = 3'd3,
    S_DT_TO_LO = 3'd4
  } state_e;

  state_e             st_q  [NUM_CH];
  state_e             st_d  [NUM_CH];
  logic [CNT_W-1:0]   cnt_q [NUM_CH];
  logic [CNT_W-1:0]   cnt_d [NUM_CH];
  logic [NUM_CH-1:0]  hi_q, hi_d;
  logic [NUM_CH-1:0]  lo_q, lo_d;
  logic [NUM_CH-1:0]  dt_q, dt_d;

  // Per-channel next state, counter and output decode
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      st_d[i]  = st_q[i];
      cnt_d[i] = cnt_q[i];
      if (!Enable) begin
        st_d[i]  = S_OFF;
        cnt_d[i] = '0;
      end else begin
        case (st_q[i])
          S_OFF: begin
            st_d[i]  = PwmIn[i] ? S_HI_ON : S_LO_ON;
            cnt_d[i] = '0;
          end
          S_LO_ON: begin
            if (PwmIn[i]) begin
              if (RiseDead == '0) begin
                st_d[i] = S_HI_ON;
              end else begin
                st_d[i]  = S_DT_TO_HI;
                cnt_d[i] = RiseDead;
              end
            end else begin
              st_d[i] = S_LO_ON;
            end
          end
          S_HI_ON: begin
            if (!PwmIn[i]) begin
              if (FallDead == '0) begin
                st_d[i] = S_LO_ON;
              end else begin
                st_d[i]  = S_DT_TO_LO;
                cnt_d[i] = FallDead;
              end
            end else begin
              st_d[i] = S_HI_ON;
            end
          end
          S_DT_TO_HI: begin
            // A reference that falls back mid-interval aborts to the old side
            if (!PwmIn[i]) begin
              st_d[i]  = S_LO_ON;
              cnt_d[i] = '0;
            end else if (cnt_q[i] <= CNT_W'(1)) begin
              st_d[i]  = S_HI_ON;
              cnt_d[i] = '0;
            end else begin
              cnt_d[i] = cnt_q[i] - CNT_W'(1);
            end
          end
          S_DT_TO_LO: begin
            if (PwmIn[i]) begin
              st_d[i]  = S_HI_ON;
              cnt_d[i] = '0;
            end else if (cnt_q[i] <= CNT_W'(1)) begin
              st_d[i]  = S_LO_ON;
              cnt_d[i] = '0;
            end else begin
              cnt_d[i] = cnt_q[i] - CNT_W'(1);
            end
          end
          default: begin
            st_d[i]  = S_OFF;
            cnt_d[i] = '0;
          end
        endcase
      end
      hi_d[i] = (st_d[i] == S_HI_ON);
      lo_d[i] = (st_d[i] == S_LO_ON);
      dt_d[i] = (st_d[i] == S_DT_TO_HI) || (st_d[i] == S_DT_TO_LO);
    end
  end

  // State, counter and registered gate-drive outputs
  always_ff @(posedge MClk or posedge Rst) begin
    if (Rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        st_q[i]  <= S_OFF;
        cnt_q[i] <= '0;
      end
      hi_q <= '0;
      lo_q <= '0;
      dt_q <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        st_q[i]  <= st_d[i];
        cnt_q[i] <= cnt_d[i];
      end
      hi_q <= hi_d;
      lo_q <= lo_d;
      dt_q <= dt_d;
    end
  end

  assign HiOut    = hi_q;
  assign LoOut    = lo_q;
  assign DtActive = dt_q;

endmodule

// File: tb/tb_multi_dead_timer.sv
// Directed-vector bench for multi_dead_timer with a short random overlap sweep.
module tb_multi_dead_timer;

  localparam int NUM_CH = 3;
  localparam int CNT_W  = 16;

  logic              MClk;
  logic              Rst;
  logic              Enable;
  logic [NUM_CH-1:0] PwmIn;
  logic [CNT_W-1:0]  RiseDead;
  logic [CNT_W-1:0]  FallDead;
  logic [NUM_CH-1:0] HiOut;
  logic [NUM_CH-1:0] LoOut;
  logic [NUM_CH-1:0] DtActive;

  int n_cmp;
  int n_err;

  multi_dead_timer #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
    .MClk     (MClk),
    .Rst      (Rst),
    .Enable   (Enable),
    .PwmIn    (PwmIn),
    .RiseDead (RiseDead),
    .FallDead (FallDead),
    .HiOut    (HiOut),
    .LoOut    (LoOut),
    .DtActive (DtActive)
  );

  initial MClk = 1'b0;
  always #5 MClk = ~MClk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge MClk);
    #1;
  endtask

  task automatic check_all(input string tag, input logic [2:0] hi, input logic [2:0] lo, input logic [2:0] dt);
    check_eq({tag, ".hi"}, 32'(HiOut), 32'(hi));
    check_eq({tag, ".lo"}, 32'(LoOut), 32'(lo));
    check_eq({tag, ".dt"}, 32'(DtActive), 32'(dt));
  endtask

  initial begin
    n_cmp    = 0;
    n_err    = 0;
    Rst      = 1'b1;
    Enable   = 1'b0;
    PwmIn    = 3'b000;
    RiseDead = 16'd4;
    FallDead = 16'd0;
    step();
    step();
    check_all("reset", 3'b000, 3'b000, 3'b000);

    // Release reset: nothing changes until the first edge
    Rst    = 1'b0;
    Enable = 1'b1;
    #1;
    check_all("rst_release", 3'b000, 3'b000, 3'b000);
    step();
    check_all("off_to_lo", 3'b000, 3'b111, 3'b000);

    // Rising handover on ch0 with 4 dead cycles
    PwmIn = 3'b001;
    step();
    check_all("rise4_k", 3'b000, 3'b110, 3'b001);
    for (int i = 1; i <= 3; i++) begin
      step();
      check_all($sformatf("rise4_k%0d", i), 3'b000, 3'b110, 3'b001);
    end
    step();
    check_all("rise4_done", 3'b001, 3'b110, 3'b000);

    // Zero dead time both ways on ch1
    RiseDead = 16'd0;
    PwmIn    = 3'b011;
    step();
    check_all("rise0_ch1", 3'b011, 3'b100, 3'b000);
    PwmIn = 3'b001;
    step();
    check_all("fall0_ch1", 3'b001, 3'b110, 3'b000);

    // Aborted rising interval on ch2
    RiseDead = 16'd10;
    PwmIn    = 3'b101;
    for (int i = 0; i < 3; i++) begin
      step();
      check_all($sformatf("abort_dt%0d", i), 3'b001, 3'b010, 3'b100);
    end
    PwmIn = 3'b001;
    step();
    check_all("abort_back", 3'b001, 3'b110, 3'b000);

    // Dead value latched at load; a later change does not stretch the interval
    RiseDead = 16'd4;
    PwmIn    = 3'b101;
    step();
    check_eq("latch_load_dt", 32'(DtActive), 32'(3'b100));
    step();
    RiseDead = 16'd9;
    step();
    step();
    check_all("latch_mid", 3'b001, 3'b010, 3'b100);
    step();
    check_all("latch_done", 3'b101, 3'b010, 3'b000);

    // Falling handover on ch2 with 2 dead cycles
    FallDead = 16'd2;
    PwmIn    = 3'b001;
    step();
    check_all("fall2_k", 3'b001, 3'b010, 3'b100);
    step();
    check_all("fall2_k1", 3'b001, 3'b010, 3'b100);
    step();
    check_all("fall2_done", 3'b001, 3'b110, 3'b000);

    // Next rising interval uses the new value of 9
    PwmIn = 3'b101;
    for (int i = 0; i < 9; i++) begin
      step();
      check_eq($sformatf("rise9_dt%0d", i), 32'({HiOut[2], DtActive[2]}), 32'(2'b01));
    end
    step();
    check_all("rise9_done", 3'b101, 3'b010, 3'b000);

    // Enable dropped mid-interval, then raised with all requests high
    RiseDead = 16'd5;
    PwmIn    = 3'b111;
    step();
    check_all("en_dt0", 3'b101, 3'b000, 3'b010);
    step();
    Enable = 1'b0;
    step();
    check_all("en_drop", 3'b000, 3'b000, 3'b000);
    Enable = 1'b1;
    step();
    check_all("en_raise", 3'b111, 3'b000, 3'b000);

    // Asynchronous reset between edges while high sides are on
    Rst = 1'b1;
    #2;
    check_all("async_rst", 3'b000, 3'b000, 3'b000);
    step();
    check_all("rst_hold", 3'b000, 3'b000, 3'b000);
    Rst   = 1'b0;
    PwmIn = 3'b010;
    #1;
    check_all("rst_rel2", 3'b000, 3'b000, 3'b000);
    step();
    check_all("rst_first_edge", 3'b010, 3'b101, 3'b000);

    // Random sweep: no channel ever drives both sides or drives during dead time
    for (int n = 0; n < 300; n++) begin
      PwmIn    = 3'($urandom_range(0, 7));
      Enable   = ($urandom_range(0, 15) != 0) ? 1'b1 : 1'b0;
      RiseDead = 16'($urandom_range(0, 3));
      FallDead = 16'($urandom_range(0, 3));
      if (n % 97 == 50) begin
        #2 Rst = 1'b1;
        #1;
        check_eq("rand_rst", 32'({HiOut, LoOut, DtActive}), 32'd0);
        Rst = 1'b0;
      end
      step();
      check_eq("rand_overlap", 32'(HiOut & LoOut), 32'd0);
      check_eq("rand_dt_excl", 32'(DtActive & (HiOut | LoOut)), 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
